// File: rtl/conv_mac_array.sv
// conv_mac_array: a row of ARRAY_SIZE fixed-point MAC lanes that accumulates one
// KERNEL_SIZE x KERNEL_SIZE convolution window per result. Every lane shares the
// per-tap weight. Stage 1 registers the full-width products. Stage 2 accumulates
// them and, on the last tap, emits a shifted and saturated result for each lane.
module conv_mac_array #(
    parameter int ARRAY_SIZE  = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_valid,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
    input  logic [DATA_WIDTH-1:0]            i_weight,
    input  logic                             i_clear,
    output logic                             o_valid,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_pixel_bus,
    output logic                             o_busy
);

    localparam int TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CNT_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    // Eight guard bits: up to 256 full-scale products can never wrap the sum.
    localparam int ACC_W  = PROD_W + 8;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    // Tap counter and stage-1 control bits
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic             out_valid_q, out_valid_d;

    // Per-lane state
    logic [PROD_W-1:0]     prod_q [ARRAY_SIZE];
    logic [PROD_W-1:0]     prod_d [ARRAY_SIZE];
    logic [ACC_W-1:0]      acc_q  [ARRAY_SIZE];
    logic [ACC_W-1:0]      acc_d  [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] res_q  [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0] res_d  [ARRAY_SIZE];

    // Per-lane combinational arithmetic
    logic [PROD_W-1:0]       prod_w  [ARRAY_SIZE];
    logic signed [ACC_W-1:0] sum_w   [ARRAY_SIZE];
    logic signed [ACC_W-1:0] shift_w [ARRAY_SIZE];
    logic [DATA_WIDTH-1:0]   sat_w   [ARRAY_SIZE];

    logic accept;
    logic last_tap;

    // Beat acceptance and tap counting; a clear discards a coincident beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        accept     = i_valid & ~i_clear;
        last_tap   = (cnt_q == LAST_TAP);
        cnt_d      = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_valid) begin
            cnt_d = last_tap ? '0 : cnt_q + CNT_W'(1);
        end
        s1_valid_d = accept;
        s1_last_d  = accept & last_tap;
    end

    // Lane arithmetic: signed product, sign-extended sum, arithmetic shift, saturation.
    always_comb begin
        logic [DATA_WIDTH-1:0] pix;
        pix = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            pix = i_pixel_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH];
            // Both operands are sign-extended to PROD_W, so the low PROD_W bits of the
            // unsigned product equal the exact signed product.
            prod_w[k]  = {{DATA_WIDTH{pix[DATA_WIDTH-1]}}, pix}
                       * {{DATA_WIDTH{i_weight[DATA_WIDTH-1]}}, i_weight};
            sum_w[k]   = $signed(acc_q[k]) + $signed({{8{prod_q[k][PROD_W-1]}}, prod_q[k]});
            shift_w[k] = sum_w[k] >>> FRAC_WIDTH;
            // The value fits when all bits above the result's sign bit match that sign bit.
            if ((&shift_w[k][ACC_W-1:DATA_WIDTH-1]) || !(|shift_w[k][ACC_W-1:DATA_WIDTH-1])) begin
                sat_w[k] = shift_w[k][DATA_WIDTH-1:0];
            end else if (shift_w[k][ACC_W-1]) begin
                sat_w[k] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                sat_w[k] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end
    end

    // Stage-1 product capture and stage-2 accumulate/emit decisions.
    always_comb begin
        out_valid_d = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        res_d       = res_q;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            if (accept) begin
                prod_d[k] = prod_w[k];
            end
        end
        if (i_clear) begin
            // An abort discards everything in flight, including a stage-1 beat.
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                acc_d[k] = '0;
            end
        end else if (s1_valid_q) begin
            if (s1_last_q) begin
                // The result includes the last product. Zeroing the accumulator here
                // means tap 1 of the next window is loaded into it, not added to it.
                out_valid_d = 1'b1;
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    res_d[k] = sat_w[k];
                    acc_d[k] = '0;
                end
            end else begin
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    acc_d[k] = sum_w[k];
                end
            end
        end
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            // NOTE: the lane arrays are small register files, so they are reset like any
            // other state. This makes the outputs read zero during reset.
            for (int k = 0; k < ARRAY_SIZE; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
        end
    end

    // Pack lane results onto the output bus; lane 0 occupies the MSBs.
    always_comb begin
        o_pixel_bus = '0;
        for (int k = 0; k < ARRAY_SIZE; k++) begin
            o_pixel_bus[(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH] = res_q[k];
        end
    end

    assign o_valid = out_valid_q;
    assign o_busy  = (cnt_q != '0) | s1_valid_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Testbench for conv_mac_array. A window-level reference model sums exact integer
// products per lane and converts each completed window with floor-shift and
// saturation. A negedge monitor compares o_valid timing, o_pixel_bus and o_busy
// against the model on every cycle.
module tb_conv_mac_array;

    localparam int N    = 6;
    localparam int DW   = 16;
    localparam int FW   = 8;
    localparam int TAPS = 9;
    localparam int BW   = N * DW;

    typedef struct {
        int            e;    // edge that sampled the last tap
        logic [BW-1:0] bus;  // expected result bus
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_clear = 1'b0;
    logic [BW-1:0] i_pixel_bus = '0;
    logic [DW-1:0] i_weight = '0;
    logic          o_valid;
    logic [BW-1:0] o_pixel_bus;
    logic          o_busy;

    conv_mac_array #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .FRAC_WIDTH (FW),
        .KERNEL_SIZE(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_pixel_bus(i_pixel_bus),
        .i_weight   (i_weight),
        .i_clear    (i_clear),
        .o_valid    (o_valid),
        .o_pixel_bus(o_pixel_bus),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            edge_cnt = 0;
    int            m_cnt = 0;
    bit            m_prev = 1'b0;
    longint        m_sum [N];
    exp_t          exp_q [$];
    logic [BW-1:0] held_bus = '0;
    logic [BW-1:0] last_bus = '0;
    int            n_pulses = 0;
    int            last_pulse_edge = 0;
    int            prev_pulse_edge = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] put_lane(input logic [BW-1:0] bus, input int k,
                                               input logic [DW-1:0] v);
        bus[(N-k)*DW-1 -: DW] = v;
        return bus;
    endfunction

    function automatic logic [DW-1:0] get_lane(input logic [BW-1:0] bus, input int k);
        return bus[(N-k)*DW-1 -: DW];
    endfunction

    function automatic logic [BW-1:0] lanes_all(input logic [DW-1:0] v);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r = put_lane(r, k, v);
        return r;
    endfunction

    // Window sum -> result: floor division by 2^FW, then clamp to the signed 16-bit range.
    function automatic logic [DW-1:0] fix_result(input longint s);
        longint r;
        r = s >>> FW;
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_val();
        logic [9:0] t;
        if ($urandom_range(0, 1) == 1) return DW'($urandom);
        t = 10'($urandom);
        return {{6{t[9]}}, t};
    endfunction

    // One clock cycle: drive inputs at the negedge, then update the model at the posedge.
    task automatic cycle(input bit v, input logic [BW-1:0] pix, input logic [DW-1:0] w,
                         input bit clr);
        logic [BW-1:0] rb;
        @(negedge clk);
        i_valid     = v;
        i_pixel_bus = pix;
        i_weight    = w;
        i_clear     = clr;
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            m_prev = 1'b0;
        end else if (clr) begin
            m_cnt  = 0;
            m_prev = 1'b0;
            for (int k = 0; k < N; k++) m_sum[k] = 0;
        end else if (v) begin
            m_prev = 1'b1;
            for (int k = 0; k < N; k++)
                m_sum[k] += longint'($signed(get_lane(pix, k))) * longint'($signed(w));
            m_cnt++;
            if (m_cnt == TAPS) begin
                rb = '0;
                for (int k = 0; k < N; k++) rb = put_lane(rb, k, fix_result(m_sum[k]));
                exp_q.push_back('{e: edge_cnt, bus: rb});
                m_cnt = 0;
                for (int k = 0; k < N; k++) m_sum[k] = 0;
            end
        end else begin
            m_prev = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    // Release reset at a negedge with idle inputs; count the following edge.
    task automatic idle_release();
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        @(posedge clk);
        edge_cnt++;
        m_prev = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        m_cnt  = 0;
        m_prev = 1'b0;
        for (int k = 0; k < N; k++) m_sum[k] = 0;
        exp_q.delete();
        held_bus = '0;
        #1;
        check("rst_async_o_valid", 128'(o_valid), 128'(0));
        check("rst_async_o_bus", 128'(o_pixel_bus), 128'(0));
        check("rst_async_o_busy", 128'(o_busy), 128'(0));
        cycle(1'b1, lanes_all(16'h0100), 16'h0100, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        idle_release();
    endtask

    task automatic beats(input int n, input logic [BW-1:0] pix, input logic [DW-1:0] w);
        for (int i = 0; i < n; i++) cycle(1'b1, pix, w, 1'b0);
    endtask

    // Monitor: compare the outputs with the model on every falling edge.
    initial begin
        forever begin
            bit ev;
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].e + 1 < edge_cnt) begin
                check("result_missing", 128'(1), 128'(0));
                void'(exp_q.pop_front());
            end
            ev = (exp_q.size() > 0) && (exp_q[0].e + 1 == edge_cnt);
            check("o_valid", 128'(o_valid), 128'(ev));
            if (ev) begin
                held_bus = exp_q[0].bus;
                void'(exp_q.pop_front());
            end
            if (o_valid) begin
                n_pulses++;
                last_bus        = o_pixel_bus;
                prev_pulse_edge = last_pulse_edge;
                last_pulse_edge = edge_cnt;
            end
            check("o_pixel_bus", 128'(o_pixel_bus), 128'(held_bus));
            check("o_busy", 128'(o_busy), 128'((m_cnt != 0) || m_prev));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            p0;
        logic [BW-1:0] ramp, ramp_exp;
        for (int k = 0; k < N; k++) m_sum[k] = 0;

        // Reset state
        #3;
        check("reset_o_valid", 128'(o_valid), 128'(0));
        check("reset_o_bus", 128'(o_pixel_bus), 128'(0));
        check("reset_o_busy", 128'(o_busy), 128'(0));
        idle_release();
        idle(2);

        // Nine unit beats -> 9.0 in every lane
        p0 = n_pulses;
        beats(9, lanes_all(16'h0100), 16'h0100);
        idle(4);
        check("unit_pulses", 128'(n_pulses - p0), 128'(1));
        check("unit_result", 128'(last_bus), 128'(lanes_all(16'h0900)));

        // Lane ramp with half weight and random gaps
        ramp = '0;
        ramp_exp = '0;
        for (int k = 0; k < N; k++) begin
            ramp     = put_lane(ramp, k, DW'(k * 16'h0100));
            ramp_exp = put_lane(ramp_exp, k, DW'(k * 16'h0480));
        end
        p0 = n_pulses;
        for (int i = 0; i < TAPS; i++) begin
            idle($urandom_range(0, 3));
            cycle(1'b1, ramp, 16'h0080, 1'b0);
        end
        idle(4);
        check("ramp_pulses", 128'(n_pulses - p0), 128'(1));
        check("ramp_lane5", 128'(get_lane(last_bus, 5)), 128'(16'h1680));
        check("ramp_result", 128'(last_bus), 128'(ramp_exp));

        // Saturation at both ends
        beats(9, lanes_all(16'h7FFF), 16'h7FFF);
        idle(4);
        check("sat_pos", 128'(last_bus), 128'(lanes_all(16'h7FFF)));
        beats(9, lanes_all(16'h8000), 16'h7FFF);
        idle(4);
        check("sat_neg", 128'(last_bus), 128'(lanes_all(16'h8000)));

        // Back-to-back windows
        p0 = n_pulses;
        beats(9, lanes_all(16'h0100), 16'h0100);
        beats(9, lanes_all(16'h0200), 16'h0100);
        idle(4);
        check("b2b_pulses", 128'(n_pulses - p0), 128'(2));
        check("b2b_spacing", 128'(last_pulse_edge - prev_pulse_edge), 128'(9));
        check("b2b_result", 128'(last_bus), 128'(lanes_all(16'h1200)));

        // Clear mid-window, coincident with a beat
        p0 = n_pulses;
        beats(4, lanes_all(16'h0300), 16'h0100);
        cycle(1'b1, lanes_all(16'h0300), 16'h0100, 1'b1);
        beats(9, lanes_all(16'h0100), 16'h0100);
        idle(4);
        check("clear_pulses", 128'(n_pulses - p0), 128'(1));
        check("clear_result", 128'(last_bus), 128'(lanes_all(16'h0900)));

        // Reset mid-window
        p0 = n_pulses;
        beats(5, lanes_all(16'h0100), 16'h0100);
        do_reset();
        beats(9, lanes_all(16'h0100), 16'h0100);
        idle(4);
        check("rst_pulses", 128'(n_pulses - p0), 128'(1));
        check("rst_result", 128'(last_bus), 128'(lanes_all(16'h0900)));

        // Random traffic: gaps, mixed magnitudes, occasional clears of partial windows
        for (int i = 0; i < 600; i++) begin
            logic [BW-1:0] pix;
            bit            v, clr;
            pix = '0;
            for (int k = 0; k < N; k++) pix = put_lane(pix, k, rand_val());
            v   = ($urandom_range(0, 9) < 7);
            clr = (m_cnt != 0) && ($urandom_range(0, 29) == 0);
            cycle(v, pix, rand_val(), clr);
        end
        idle(5);
        check("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_mac_array.md
CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 6: number of parallel MAC lanes, 1..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement pixel, weight and result width.
REQ-003 SHALL have parameter FRAC_WIDTH, default 8: fractional bits of the fixed-point format, less than DATA_WIDTH.
REQ-004 SHALL have parameter KERNEL_SIZE, default 3: window edge, giving TAPS = KERNEL_SIZE*KERNEL_SIZE beats per result, with TAPS ≤ 256.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_valid, input, 1 bit: the pixel bus and weight carry one tap this cycle.
REQ-008 SHALL have port i_pixel_bus, input, ARRAY_SIZE*DATA_WIDTH bits: lane k at bits [(ARRAY_SIZE-k)*DATA_WIDTH-1 -: DATA_WIDTH], so lane 0 occupies the MSBs.
REQ-009 SHALL have port i_weight, input, DATA_WIDTH bits: one weight per tap, shared by all lanes.
REQ-010 SHALL have port i_clear, input, 1 bit: synchronous abort of the current window.
REQ-011 SHALL have port o_valid, output, 1 bit: a one-cycle strobe marking a new result.
REQ-012 SHALL have port o_pixel_bus, output, ARRAY_SIZE*DATA_WIDTH bits: per-lane results, using the same lane mapping as i_pixel_bus.
REQ-013 SHALL have port o_busy, output, 1 bit: a window is partially accumulated or a result is in flight.

Function
REQ-014 SHALL, in pipeline stage 1, register the per-lane product pixel*weight at full width (2*DATA_WIDTH bits) together with a registered valid bit and a registered last-tap flag.
REQ-015 SHALL, in pipeline stage 2, add the stage-1 product into a per-lane accumulator of 2*DATA_WIDTH+8 bits, sign-extended, that never wraps.
REQ-016 SHALL maintain a tap counter that increments on each accepted i_valid beat, counts 0..TAPS-1, and wraps to 0 on the last tap.
REQ-017 SHALL tolerate gaps in i_valid of any length, with no effect on the counter or the accumulators.
REQ-018 SHALL, on a stage-2 beat flagged last, load each lane's result from the sum (accumulator + product), not from the accumulator alone.
REQ-019 SHALL form each lane result by arithmetic right shift of that sum by FRAC_WIDTH (truncation toward minus infinity).
REQ-020 SHALL saturate each lane result to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-021 SHALL, on that same last-tap edge, assert o_valid for exactly one cycle and zero the accumulators.
REQ-022 SHALL assert o_valid in cycle N+2 when the last tap is sampled at the edge ending cycle N (latency 2).
REQ-023 SHALL hold o_pixel_bus stable between results, updating it only on o_valid.
REQ-024 SHALL support back-to-back windows: tap 1 of window W+1 may arrive in the cycle after the last tap of window W, with the first product of W+1 loaded into the accumulator rather than added to it.
REQ-025 SHALL, on i_clear, zero the tap counter, the accumulators and the stage-1 valid and last bits.
REQ-026 SHALL, on i_clear, produce no o_valid for the aborted window and leave o_pixel_bus unchanged.
REQ-027 SHALL give i_clear priority over i_valid in the same cycle, discarding that beat.
REQ-028 SHALL drive o_busy = (tap counter ≠ 0) OR stage-1 valid.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously zero all registers: o_valid=0, o_pixel_bus=0, o_busy=0, counter, accumulators and pipeline bits.
REQ-030 SHALL, on rst_n low mid-window, discard that window with no o_valid, and accept the first beat after reset deassertion as tap 1.

Verification (defaults: DATA_WIDTH=16, FRAC_WIDTH=8, KERNEL_SIZE=3, ARRAY_SIZE=6)
REQ-031 SHALL cover: 9 consecutive beats with all pixels 0x0100 and weight 0x0100 -> all lanes 0x0900, o_valid high for one cycle, two cycles after the 9th beat, o_busy low afterwards.
REQ-032 SHALL cover: lane k pixel = k*0x0100, weight 0x0080, 9 beats with random i_valid gaps -> lane k = k*0x0480 (lane 5 = 0x1680), one o_valid.
REQ-033 SHALL cover: pixels 0x7FFF with weight 0x7FFF -> all lanes 0x7FFF; pixels 0x8000 with weight 0x7FFF -> all lanes 0x8000.
REQ-034 SHALL cover: two windows back-to-back (18 consecutive beats, window 1 all 0x0100, window 2 all 0x0200, weight 0x0100) -> o_valid in two cycles nine apart, results 0x0900 then 0x1200.
REQ-035 SHALL cover: 4 beats, then i_clear together with an i_valid beat, then 9 beats of 0x0100 with weight 0x0100 -> exactly one o_valid, result 0x0900, with o_pixel_bus unchanged before it.
REQ-036 SHALL cover: rst_n pulsed low after 5 beats -> outputs 0 immediately, no o_valid; next 9 beats of 0x0100 with weight 0x0100 -> 0x0900.
